// File: rtl/pc_pkg.sv
// ---------------------------------------------------------------------------
// pc_pkg: shared definitions for the ForthCPU program-counter unit.
//   - PC_BASEX_* / PC_OFFSETX_* adder operand select encodings
//   - PC_RESET_ADDR: address loaded into PC_A on reset
//   - lvl_width(): width of an in-service level (0..NUM_INT, NUM_INT = idle)
// Optional build macro used by the unit: PC_INT_MASK_EN.
// ---------------------------------------------------------------------------
package pc_pkg;

    typedef enum logic [1:0] {
        PC_BASEX_PC_A = 2'd0,
        PC_BASEX_REGB = 2'd1,
        PC_BASEX_ZERO = 2'd2,
        PC_BASEX_RSVD = 2'd3   // treated as PC_A
    } pc_basex_e;

    typedef enum logic [1:0] {
        PC_OFFSETX_0   = 2'd0,
        PC_OFFSETX_2   = 2'd1,
        PC_OFFSETX_4   = 2'd2,
        PC_OFFSETX_DIN = 2'd3
    } pc_offsetx_e;

    localparam int unsigned PC_RESET_ADDR = 0;

    // Levels run 0..num_int, where num_int encodes "nothing in service".
    function automatic int lvl_width(input int num_int);
        return $clog2(num_int + 1);
    endfunction

endpackage

// File: rtl/pc_vectored_unit_if.sv
// ---------------------------------------------------------------------------
// pc_vectored_unit_if: decoder-side bus of the program-counter unit.
//   master : decoder / bench (drives phase, select, operand, interrupt lines)
//   slave  : pc_vectored_unit (drives PC_A, PC_A_NEXT, HERE, INT_ACK,
//            INT_LEVEL, STACK_FULL, STACK_ERR)
// With PC_INT_MASK_EN defined the bus also carries IMASK_WE.
// ---------------------------------------------------------------------------
interface pc_vectored_unit_if #(
    parameter int AW      = 16,
    parameter int NUM_INT = 4
);
    import pc_pkg::*;

    localparam int LW = lvl_width(NUM_INT);

    logic               FETCH;
    logic               DECODE;
    logic               PC_ENX;
    logic [1:0]         PC_BASEX;
    logic [1:0]         PC_OFFSETX;
    logic [AW-1:0]      REGB_DOUT;
    logic [AW-1:0]      DIN;
    logic               RETI;
    logic [NUM_INT-1:0] INT_REQ;
`ifdef PC_INT_MASK_EN
    logic               IMASK_WE;
`endif
    logic [NUM_INT-1:0] INT_ACK;
    logic [AW-1:0]      HERE;
    logic [AW-1:0]      PC_A_NEXT;
    logic [AW-1:0]      PC_A;
    logic [LW-1:0]      INT_LEVEL;
    logic               STACK_FULL;
    logic               STACK_ERR;

    modport master (
`ifdef PC_INT_MASK_EN
        output IMASK_WE,
`endif
        output FETCH, DECODE, PC_ENX, PC_BASEX, PC_OFFSETX, REGB_DOUT, DIN, RETI, INT_REQ,
        input  INT_ACK, HERE, PC_A_NEXT, PC_A, INT_LEVEL, STACK_FULL, STACK_ERR
    );

    modport slave (
`ifdef PC_INT_MASK_EN
        input  IMASK_WE,
`endif
        input  FETCH, DECODE, PC_ENX, PC_BASEX, PC_OFFSETX, REGB_DOUT, DIN, RETI, INT_REQ,
        output INT_ACK, HERE, PC_A_NEXT, PC_A, INT_LEVEL, STACK_FULL, STACK_ERR
    );

endinterface

// File: rtl/pc_ret_stack.sv
// ---------------------------------------------------------------------------
// pc_ret_stack: return-address LIFO for nested interrupts.
//   clk, rst : clock, synchronous active-high reset (empties the stack)
//   push/din : store din on top (ignored when full)
//   pop      : discard top entry (ignored when empty)
//   top      : current top entry (undefined when empty)
//   full, empty, count : occupancy
// Push and pop are never requested together by the PC unit.
// ---------------------------------------------------------------------------
module pc_ret_stack #(
    parameter int W     = 19,
    parameter int DEPTH = 4,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  top,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [W-1:0] mem [DEPTH];

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign top   = mem[count - CW'(1)];

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (push && !full) begin
            count <= count + CW'(1);
        end else if (pop && !empty) begin
            count <= count - CW'(1);
        end
    end

    // Entry storage is not reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (!rst && push && !full) begin
            mem[count] <= din;
        end
    end

endmodule

// File: rtl/pc_vectored_unit.sv
// ---------------------------------------------------------------------------
// pc_vectored_unit: ForthCPU program counter with NUM_INT prioritised,
// nestable interrupt vectors.
//   CLK, RESET : clock, synchronous active-high reset
//   bus        : pc_vectored_unit_if.slave (phase qualifiers, adder selects,
//                operands, RETI, INT_REQ in; PC_A, PC_A_NEXT, HERE, INT_ACK,
//                INT_LEVEL, STACK_FULL, STACK_ERR out)
// Optional macro PC_INT_MASK_EN adds IMASK_WE and a per-line mask register
// (loaded from DIN, reset to all ones).
// ---------------------------------------------------------------------------
module pc_vectored_unit
    import pc_pkg::*;
#(
    parameter int AW          = 16,
    parameter int NUM_INT     = 4,
    parameter int STACK_DEPTH = 4,
    parameter int VEC_BASE    = 4,
    parameter int VEC_STRIDE  = 4
) (
    input  logic              CLK,
    input  logic              RESET,
    pc_vectored_unit_if.slave bus
);

    localparam int LW = lvl_width(NUM_INT);
    localparam int CW = $clog2(STACK_DEPTH + 1);
    localparam logic [LW-1:0] LVL_NONE = LW'(NUM_INT);

    logic [AW-1:0]      arga, argb, sum;
    logic [AW-1:0]      pc_a, here;
    logic [LW-1:0]      int_level;
    logic [NUM_INT-1:0] int_ack, req_en;
    logic               stack_err;
    logic               step, push, pop;
    logic               st_full, st_empty;
    logic [CW-1:0]      st_count;
    logic [AW+LW-1:0]   st_top;
    logic [AW-1:0]      top_addr;
    logic [LW-1:0]      top_lvl;
    logic               take_hit, tc_hit;
    logic [LW-1:0]      take_idx, tc_idx;
    logic               do_tc, do_take, do_ret;

    function automatic logic [AW-1:0] vec_addr(input logic [LW-1:0] idx);
        return AW'(VEC_BASE) + AW'(idx) * AW'(VEC_STRIDE);
    endfunction

    always_comb begin
        case (pc_basex_e'(bus.PC_BASEX))
            PC_BASEX_REGB: arga = bus.REGB_DOUT;
            PC_BASEX_ZERO: arga = '0;
            default:       arga = pc_a;
        endcase
        case (pc_offsetx_e'(bus.PC_OFFSETX))
            PC_OFFSETX_2:   argb = AW'(2);
            PC_OFFSETX_4:   argb = AW'(4);
            PC_OFFSETX_DIN: argb = bus.DIN;
            default:        argb = '0;
        endcase
    end

    assign sum = arga + argb;

`ifdef PC_INT_MASK_EN
    logic [NUM_INT-1:0] int_mask;

    // A take in the same cycle as a mask write sees the old mask.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            int_mask <= '1;
        end else if (bus.IMASK_WE) begin
            int_mask <= bus.DIN[NUM_INT-1:0];
        end
    end

    assign req_en = bus.INT_REQ & int_mask;
`else
    assign req_en = bus.INT_REQ;
`endif

    assign {top_addr, top_lvl} = st_top;

    // Two priority searches: against the current level for a fresh take and
    // against the interrupted level (stack top) for tail-chaining on RETI.
    // Scanning downwards leaves the lowest qualifying index.
    always_comb begin
        take_hit = 1'b0;
        take_idx = '0;
        tc_hit   = 1'b0;
        tc_idx   = '0;
        for (int i = NUM_INT - 1; i >= 0; i--) begin
            if (req_en[i] && (LW'(i) < int_level)) begin
                take_hit = 1'b1;
                take_idx = LW'(i);
            end
            if (req_en[i] && (LW'(i) < top_lvl)) begin
                tc_hit = 1'b1;
                tc_idx = LW'(i);
            end
        end
    end

    assign step    = bus.PC_ENX && bus.FETCH;
    assign do_tc   = step && bus.RETI && tc_hit && (st_count != '0);
    assign do_take = step && !bus.RETI && take_hit && !st_full;
    assign do_ret  = step && bus.RETI && !do_tc && !st_empty;
    assign push    = do_take;
    assign pop     = do_ret;

    pc_ret_stack #(
        .W     (AW + LW),
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk   (CLK),
        .rst   (RESET),
        .push  (push),
        .pop   (pop),
        .din   ({sum, int_level}),
        .top   (st_top),
        .full  (st_full),
        .empty (st_empty),
        .count (st_count)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            pc_a      <= AW'(PC_RESET_ADDR);
            here      <= '0;
            int_level <= LVL_NONE;
            int_ack   <= '0;
            stack_err <= 1'b0;
        end else begin
            int_ack <= '0;
            if (bus.PC_ENX && bus.DECODE) begin
                here <= sum;
            end
            if (do_tc) begin
                int_level <= tc_idx;
                pc_a      <= vec_addr(tc_idx);
                int_ack   <= NUM_INT'(1) << tc_idx;
            end else if (do_take) begin
                int_level <= take_idx;
                pc_a      <= vec_addr(take_idx);
                int_ack   <= NUM_INT'(1) << take_idx;
            end else if (do_ret) begin
                pc_a      <= top_addr;
                int_level <= top_lvl;
            end else if (step) begin
                pc_a <= sum;
                if (bus.RETI) begin
                    stack_err <= 1'b1;
                end
            end
        end
    end

    assign bus.PC_A_NEXT  = sum;
    assign bus.PC_A       = pc_a;
    assign bus.HERE       = here;
    assign bus.INT_LEVEL  = int_level;
    assign bus.INT_ACK    = int_ack;
    assign bus.STACK_FULL = st_full;
    assign bus.STACK_ERR  = stack_err;

endmodule

// File: tb/tb_pc_vectored_unit.sv
// ---------------------------------------------------------------------------
// tb_pc_vectored_unit: directed scenarios followed by random stimulus for
// pc_vectored_unit (STACK_DEPTH = 2), compared against a queue-based model.
// ---------------------------------------------------------------------------
module tb_pc_vectored_unit;

    localparam int DEPTH = 2;

    logic CLK = 1'b0;
    logic RESET;

    always #5 CLK = ~CLK;

    pc_vectored_unit_if #(.AW(16), .NUM_INT(4)) bus ();

    pc_vectored_unit #(
        .AW          (16),
        .NUM_INT     (4),
        .STACK_DEPTH (DEPTH),
        .VEC_BASE    (4),
        .VEC_STRIDE  (4)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    typedef struct {
        logic [15:0] a;
        int          l;
    } ent_t;

    int n_chk  = 0;
    int n_pass = 0;

    logic [15:0] m_pc, m_here;
    int          m_lvl;
    bit          m_err;
    logic [3:0]  m_ack;
    ent_t        q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [15:0] vec(input int i);
        return 16'(4 + i * 4);
    endfunction

    function automatic int pick(input logic [3:0] rq, input int lim);
        for (int i = 0; i < 4; i++) begin
            if (rq[i] && i < lim) return i;
        end
        return -1;
    endfunction

    function automatic logic [15:0] model_sum(input logic [1:0] b, input logic [1:0] o,
                                              input logic [15:0] rg, input logic [15:0] dn);
        int base, off;
        base = (b == 2'd1) ? int'(rg) : (b == 2'd2) ? 0 : int'(m_pc);
        off  = (o == 2'd0) ? 0 : (o == 2'd1) ? 2 : (o == 2'd2) ? 4 : int'(dn);
        return 16'((base + off) % 65536);
    endfunction

    task automatic model_reset();
        m_pc = 16'h0; m_here = 16'h0; m_lvl = 4; m_err = 1'b0; m_ack = 4'h0;
        q.delete();
    endtask

    task automatic model_step(input bit f, input bit d, input bit e, input bit r,
                              input logic [3:0] rq, input logic [15:0] s);
        int   tc, tk;
        ent_t ent;
        m_ack = 4'h0;
        if (e && d) m_here = s;
        if (e && f) begin
            tc = (q.size() > 0) ? pick(rq, q[q.size()-1].l) : -1;
            tk = (q.size() < DEPTH) ? pick(rq, m_lvl) : -1;
            if (r && tc >= 0) begin
                m_lvl = tc; m_pc = vec(tc); m_ack[tc] = 1'b1;
            end else if (!r && tk >= 0) begin
                ent.a = s; ent.l = m_lvl;
                q.push_back(ent);
                m_lvl = tk; m_pc = vec(tk); m_ack[tk] = 1'b1;
            end else if (r && q.size() > 0) begin
                ent = q.pop_back();
                m_pc = ent.a; m_lvl = ent.l;
            end else begin
                m_pc = s;
                if (r) m_err = 1'b1;
            end
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".pc_a"},   32'(bus.PC_A),       32'(m_pc));
        chk({tag, ".here"},   32'(bus.HERE),       32'(m_here));
        chk({tag, ".level"},  32'(bus.INT_LEVEL),  32'(m_lvl));
        chk({tag, ".ack"},    32'(bus.INT_ACK),    32'(m_ack));
        chk({tag, ".full"},   32'(bus.STACK_FULL), 32'(q.size() == DEPTH));
        chk({tag, ".err"},    32'(bus.STACK_ERR),  32'(m_err));
    endtask

    task automatic cyc(input bit f, input bit d, input bit e, input logic [1:0] b,
                       input logic [1:0] o, input logic [15:0] rg, input logic [15:0] dn,
                       input bit r, input logic [3:0] rq, input string tag);
        logic [15:0] s;
        bus.FETCH = f; bus.DECODE = d; bus.PC_ENX = e;
        bus.PC_BASEX = b; bus.PC_OFFSETX = o;
        bus.REGB_DOUT = rg; bus.DIN = dn; bus.RETI = r; bus.INT_REQ = rq;
        #1;
        s = model_sum(b, o, rg, dn);
        chk({tag, ".next"}, 32'(bus.PC_A_NEXT), 32'(s));
        model_step(f, d, e, r, rq, s);
        @(posedge CLK); #1;
        check_state(tag);
    endtask

    task automatic step(input logic [1:0] b, input logic [1:0] o, input logic [15:0] dn,
                        input bit r, input logic [3:0] rq, input string tag);
        cyc(1'b1, 1'b0, 1'b1, b, o, 16'h0, dn, r, rq, tag);
    endtask

    task automatic rst_cyc(input string tag);
        RESET = 1'b1;
        bus.FETCH = 1'b1; bus.DECODE = 1'b1; bus.PC_ENX = 1'b1; bus.RETI = 1'b1;
        bus.INT_REQ = 4'hF;
        @(posedge CLK); #1;
        RESET = 1'b0;
        model_reset();
        check_state(tag);
    endtask

    initial begin
        RESET = 1'b0;
        bus.FETCH = 0; bus.DECODE = 0; bus.PC_ENX = 0; bus.PC_BASEX = 0; bus.PC_OFFSETX = 0;
        bus.REGB_DOUT = 0; bus.DIN = 0; bus.RETI = 0; bus.INT_REQ = 0;
`ifdef PC_INT_MASK_EN
        bus.IMASK_WE = 1'b0;
`endif
        model_reset();
        @(posedge CLK); #1;

        // Reset and plain stepping
        rst_cyc("reset");
        chk("reset_pc", 32'(bus.PC_A), 32'h0);
        chk("reset_lvl", 32'(bus.INT_LEVEL), 32'd4);
        step(2'd0, 2'd1, 16'h0, 0, 4'h0, "s1");
        step(2'd0, 2'd1, 16'h0, 0, 4'h0, "s2");
        step(2'd0, 2'd1, 16'h0, 0, 4'h0, "s3");
        chk("seq_pc6", 32'(bus.PC_A), 32'h6);
        cyc(1'b0, 1'b1, 1'b1, 2'd0, 2'd1, 16'h0, 16'h0, 0, 4'h0, "decode");
        chk("here_sum", 32'(bus.HERE), 32'h8);
        chk("decode_hold_pc", 32'(bus.PC_A), 32'h6);

        // Single take and return
        step(2'd2, 2'd3, 16'h0010, 0, 4'h0, "load10");
        step(2'd0, 2'd1, 16'h0, 0, 4'b0100, "take2");
        chk("take2_pc", 32'(bus.PC_A), 32'h000C);
        chk("take2_ack", 32'(bus.INT_ACK), 32'b0100);
        chk("take2_lvl", 32'(bus.INT_LEVEL), 32'd2);
        step(2'd0, 2'd1, 16'h0, 1, 4'h0, "ret2");
        chk("ret2_pc", 32'(bus.PC_A), 32'h0012);
        chk("ret2_lvl", 32'(bus.INT_LEVEL), 32'd4);

        // Nesting, lower priority ignored, tail-chain
        step(2'd0, 2'd1, 16'h0, 0, 4'b0100, "n_take2");
        step(2'd0, 2'd1, 16'h0, 0, 4'b0010, "n_take1");
        chk("nest_pc", 32'(bus.PC_A), 32'h0008);
        chk("nest_full", 32'(bus.STACK_FULL), 32'd1);
        step(2'd0, 2'd1, 16'h0, 0, 4'b1000, "n_ign3");
        chk("ign3_pc", 32'(bus.PC_A), 32'h000A);
        chk("ign3_ack", 32'(bus.INT_ACK), 32'h0);
        step(2'd0, 2'd1, 16'h0, 1, 4'b1000, "n_ret1");
        step(2'd0, 2'd1, 16'h0, 1, 4'b1000, "tail3");
        chk("tail3_pc", 32'(bus.PC_A), 32'h0010);
        chk("tail3_ack", 32'(bus.INT_ACK), 32'b1000);
        chk("tail3_lvl", 32'(bus.INT_LEVEL), 32'd3);
        step(2'd0, 2'd1, 16'h0, 1, 4'h0, "tail3_ret");

        // Saturation, tail-chain while full, underflow
        step(2'd0, 2'd1, 16'h0, 0, 4'b0100, "f_take2");
        step(2'd0, 2'd1, 16'h0, 0, 4'b0010, "f_take1");
        step(2'd0, 2'd1, 16'h0, 0, 4'b0001, "f_block0");
        chk("full_block_pc", 32'(bus.PC_A), 32'h000A);
        chk("full_block_ack", 32'(bus.INT_ACK), 32'h0);
        step(2'd0, 2'd1, 16'h0, 1, 4'b0001, "f_tail0");
        chk("full_tail_pc", 32'(bus.PC_A), 32'h0004);
        step(2'd0, 2'd1, 16'h0, 1, 4'h0, "f_ret_a");
        step(2'd0, 2'd1, 16'h0, 1, 4'h0, "f_ret_b");
        step(2'd0, 2'd1, 16'h0, 1, 4'h0, "underflow");
        chk("uflow_err", 32'(bus.STACK_ERR), 32'd1);
        chk("uflow_pc", 32'(bus.PC_A), 32'h0018);
        step(2'd0, 2'd1, 16'h0, 0, 4'h0, "err_sticky");

        // Wrap and reset mid-nesting
        step(2'd2, 2'd3, 16'hFFFE, 0, 4'h0, "loadFFFE");
        step(2'd0, 2'd1, 16'h0, 0, 4'h0, "wrap");
        chk("wrap_pc", 32'(bus.PC_A), 32'h0000);
        step(2'd0, 2'd1, 16'h0, 0, 4'b0100, "m_take");
        rst_cyc("mid_reset");
        chk("midrst_lvl", 32'(bus.INT_LEVEL), 32'd4);
        chk("midrst_full", 32'(bus.STACK_FULL), 32'd0);

        // Randomised traffic against the model
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 63) == 0) begin
                rst_cyc("rnd_reset");
            end else begin
                cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 7) != 0),
                    2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                    16'($urandom), 16'($urandom),
                    1'($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15)),
                    "rnd");
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
